// File: rtl/reflet_regbank_if.sv
// ALU result / load-tracking bus between the reflet datapath and its register bank.
interface reflet_regbank_if #(
    parameter int wordsize = 16
) ();
    logic                wb_en;
    logic [wordsize-1:0] wb_data;
    logic [3:0]          wb_reg;
    logic                pc_inc;
    logic [3:0]          other_id;
    logic                ld_issue;
    logic [3:0]          ld_dest;
    logic                ld_done;
    logic [wordsize-1:0] ld_data;
    logic [wordsize-1:0] working_register;
    logic [wordsize-1:0] other_register;
    logic [wordsize-1:0] status_register;
    logic [wordsize-1:0] program_counter;
    logic                ld_busy;
    logic                hazard;
    logic                ld_overrun;

    modport master (
        output wb_en, wb_data, wb_reg, pc_inc, other_id,
        output ld_issue, ld_dest, ld_done, ld_data,
        input  working_register, other_register, status_register, program_counter,
        input  ld_busy, hazard, ld_overrun
    );

    modport slave (
        input  wb_en, wb_data, wb_reg, pc_inc, other_id,
        input  ld_issue, ld_dest, ld_done, ld_data,
        output working_register, other_register, status_register, program_counter,
        output ld_busy, hazard, ld_overrun
    );
endinterface

// File: rtl/reflet_regbank.sv
// Register bank and write-back unit of the reflet core: 16 registers, PC update
// and single outstanding load tracking with operand hazard detection.
module reflet_regbank #(
    parameter int                  wordsize = 16,
    parameter logic [3:0]          SR_ID    = 4'd12,
    parameter logic [3:0]          PC_ID    = 4'd14,
    parameter logic [wordsize-1:0] RESET_PC = '0
) (
    input logic             clk,
    input logic             reset,
    reflet_regbank_if.slave bus
);
    typedef enum logic {
        IDLE    = 1'b0,
        PENDING = 1'b1
    } ld_state_t;

    ld_state_t           state, state_next;
    logic [3:0]          pend_dest, pend_dest_next;
    logic                overrun, overrun_next;
    logic                ld_wr;
    logic [wordsize-1:0] regs      [16];
    logic [wordsize-1:0] regs_next [16];

    function automatic logic [wordsize-1:0] pc_plus_one(input logic [wordsize-1:0] pc);
        return pc + {{(wordsize-1){1'b0}}, 1'b1};
    endfunction

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            pend_dest <= 4'd0;
            overrun   <= 1'b0;
        end else begin
            state     <= state_next;
            pend_dest <= pend_dest_next;
            overrun   <= overrun_next;
        end
    end

    always_comb begin
        state_next     = state;
        pend_dest_next = pend_dest;
        overrun_next   = overrun;
        ld_wr          = 1'b0;
        case (state)
            IDLE: begin
                if (bus.ld_issue) begin
                    state_next     = PENDING;
                    pend_dest_next = bus.ld_dest;
                end
            end
            PENDING: begin
                if (bus.ld_done) begin
                    ld_wr = 1'b1;
                    if (bus.ld_issue) pend_dest_next = bus.ld_dest;
                    else              state_next     = IDLE;
                end else if (bus.ld_issue) begin
                    // Only one load can be tracked; the second one is dropped.
                    overrun_next = 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Later assignments take priority: load completion > ALU write-back > pc_inc.
    always_comb begin
        regs_next = regs;
        if (bus.wb_en) begin
            regs_next[bus.wb_reg] = bus.wb_data;
        end
        if (bus.pc_inc && !(bus.wb_en && bus.wb_reg == PC_ID)) begin
            regs_next[PC_ID] = pc_plus_one(regs[PC_ID]);
        end
        if (ld_wr) begin
            regs_next[pend_dest] = bus.ld_data;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 16; i++) begin
                regs[i] <= (4'(i) == PC_ID) ? RESET_PC : '0;
            end
        end else begin
            regs <= regs_next;
        end
    end

    assign bus.working_register = regs[0];
    assign bus.other_register   = regs[bus.other_id];
    assign bus.status_register  = regs[SR_ID];
    assign bus.program_counter  = regs[PC_ID];
    assign bus.ld_busy          = (state == PENDING);
    assign bus.ld_overrun       = overrun;
    assign bus.hazard           = (state == PENDING) &&
                                  (pend_dest == 4'd0 || pend_dest == bus.other_id ||
                                   pend_dest == SR_ID);
endmodule

// File: tb/tb_reflet_regbank.sv
// Directed self-checking bench for reflet_regbank.
module tb_reflet_regbank;
    localparam logic [3:0] SR_ID = 4'd12;
    localparam logic [3:0] PC_ID = 4'd14;

    logic clk = 1'b0;
    logic reset;
    int   n_checks = 0;
    int   n_fail   = 0;

    always #5 clk = ~clk;

    reflet_regbank_if #(.wordsize(16)) bus ();

    reflet_regbank #(
        .wordsize(16),
        .SR_ID   (SR_ID),
        .PC_ID   (PC_ID),
        .RESET_PC(16'h0100)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.wb_en    = 1'b0;
        bus.wb_data  = 16'h0000;
        bus.wb_reg   = 4'd0;
        bus.pc_inc   = 1'b0;
        bus.ld_issue = 1'b0;
        bus.ld_dest  = 4'd0;
        bus.ld_done  = 1'b0;
        bus.ld_data  = 16'h0000;
    endtask

    task automatic test_reset();
        logic [15:0] exp;
        reset = 1'b1;
        idle_inputs();
        bus.other_id = 4'd0;
        tick();
        tick();
        reset = 1'b0;
        tick();
        for (int i = 0; i < 16; i++) begin
            bus.other_id = 4'(i);
            #1;
            exp = (4'(i) == PC_ID) ? 16'h0100 : 16'h0000;
            n_checks++;
            if (bus.other_register !== exp) begin
                $display("FAIL reset_reg%0d: got %h expected %h", i, bus.other_register, exp);
                n_fail++;
            end
        end
        n_checks++;
        if ({bus.hazard, bus.ld_busy, bus.ld_overrun} !== 3'b000) begin
            $display("FAIL reset_flags: got %b expected 000", {bus.hazard, bus.ld_busy, bus.ld_overrun});
            n_fail++;
        end
        bus.pc_inc = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            tick();
            exp = 16'h0100 + 16'(i);
            n_checks++;
            if (bus.program_counter !== exp) begin
                $display("FAIL pc_inc%0d: got %h expected %h", i, bus.program_counter, exp);
                n_fail++;
            end
        end
        bus.pc_inc = 1'b0;
    endtask

    task automatic test_writeback();
        bus.wb_en    = 1'b1;
        bus.wb_reg   = 4'd3;
        bus.wb_data  = 16'hBEEF;
        bus.other_id = 4'd3;
        #1;
        n_checks++;
        if (bus.other_register !== 16'h0000) begin
            $display("FAIL wb_r3_before: got %h expected 0000", bus.other_register);
            n_fail++;
        end
        tick();
        bus.wb_en = 1'b0;
        n_checks++;
        if (bus.other_register !== 16'hBEEF) begin
            $display("FAIL wb_r3_after: got %h expected beef", bus.other_register);
            n_fail++;
        end
        bus.wb_en  = 1'b1;
        bus.wb_reg = SR_ID;
        #1;
        n_checks++;
        if (bus.status_register !== 16'h0000) begin
            $display("FAIL wb_sr_before: got %h expected 0000", bus.status_register);
            n_fail++;
        end
        tick();
        bus.wb_en = 1'b0;
        n_checks++;
        if (bus.status_register !== 16'hBEEF) begin
            $display("FAIL wb_sr_after: got %h expected beef", bus.status_register);
            n_fail++;
        end
    endtask

    task automatic test_pc();
        bus.wb_en   = 1'b1;
        bus.wb_reg  = PC_ID;
        bus.wb_data = 16'hFFFF;
        tick();
        bus.wb_en = 1'b0;
        n_checks++;
        if (bus.program_counter !== 16'hFFFF) begin
            $display("FAIL pc_jump_ffff: got %h expected ffff", bus.program_counter);
            n_fail++;
        end
        bus.pc_inc = 1'b1;
        tick();
        n_checks++;
        if (bus.program_counter !== 16'h0000) begin
            $display("FAIL pc_wrap: got %h expected 0000", bus.program_counter);
            n_fail++;
        end
        bus.wb_en   = 1'b1;
        bus.wb_data = 16'h0040;
        tick();
        n_checks++;
        if (bus.program_counter !== 16'h0040) begin
            $display("FAIL pc_jump_over_inc: got %h expected 0040", bus.program_counter);
            n_fail++;
        end
        // Load completion to the PC outranks both the jump and the increment.
        bus.wb_en    = 1'b0;
        bus.pc_inc   = 1'b0;
        bus.ld_issue = 1'b1;
        bus.ld_dest  = PC_ID;
        tick();
        bus.ld_issue = 1'b0;
        bus.ld_done  = 1'b1;
        bus.ld_data  = 16'h0200;
        bus.wb_en    = 1'b1;
        bus.wb_data  = 16'h0300;
        bus.pc_inc   = 1'b1;
        tick();
        idle_inputs();
        n_checks++;
        if (bus.program_counter !== 16'h0200) begin
            $display("FAIL pc_load_priority: got %h expected 0200", bus.program_counter);
            n_fail++;
        end
    endtask

    task automatic test_load();
        bus.other_id = 4'd7;
        bus.ld_issue = 1'b1;
        bus.ld_dest  = 4'd0;
        tick();
        bus.ld_issue = 1'b0;
        tick();
        n_checks++;
        if ({bus.ld_busy, bus.hazard} !== 2'b11) begin
            $display("FAIL load_r0_pending: got busy/hazard %b expected 11", {bus.ld_busy, bus.hazard});
            n_fail++;
        end
        bus.ld_done = 1'b1;
        bus.ld_data = 16'h1234;
        bus.wb_en   = 1'b1;
        bus.wb_reg  = 4'd0;
        bus.wb_data = 16'h5555;
        tick();
        idle_inputs();
        n_checks++;
        if (bus.working_register !== 16'h1234) begin
            $display("FAIL load_r0_value: got %h expected 1234", bus.working_register);
            n_fail++;
        end
        n_checks++;
        if ({bus.ld_busy, bus.hazard} !== 2'b00) begin
            $display("FAIL load_r0_done: got busy/hazard %b expected 00", {bus.ld_busy, bus.hazard});
            n_fail++;
        end
        bus.ld_issue = 1'b1;
        bus.ld_dest  = 4'd9;
        bus.other_id = 4'd8;
        tick();
        bus.ld_issue = 1'b0;
        n_checks++;
        if ({bus.ld_busy, bus.hazard} !== 2'b10) begin
            $display("FAIL hazard_other_miss: got busy/hazard %b expected 10", {bus.ld_busy, bus.hazard});
            n_fail++;
        end
        bus.other_id = 4'd9;
        #1;
        n_checks++;
        if (bus.hazard !== 1'b1) begin
            $display("FAIL hazard_other_hit: got %b expected 1", bus.hazard);
            n_fail++;
        end
        bus.wb_en   = 1'b1;
        bus.wb_reg  = 4'd9;
        bus.wb_data = 16'hAAAA;
        tick();
        bus.wb_en = 1'b0;
        n_checks++;
        if (bus.other_register !== 16'hAAAA) begin
            $display("FAIL wb_to_pending: got %h expected aaaa", bus.other_register);
            n_fail++;
        end
        bus.ld_done = 1'b1;
        bus.ld_data = 16'h0009;
        tick();
        bus.ld_done = 1'b0;
        n_checks++;
        if (bus.other_register !== 16'h0009) begin
            $display("FAIL load_overwrites_wb: got %h expected 0009", bus.other_register);
            n_fail++;
        end
        bus.other_id = 4'd1;
        bus.ld_issue = 1'b1;
        bus.ld_dest  = SR_ID;
        tick();
        bus.ld_issue = 1'b0;
        n_checks++;
        if (bus.hazard !== 1'b1) begin
            $display("FAIL hazard_sr: got %b expected 1", bus.hazard);
            n_fail++;
        end
        bus.ld_done = 1'b1;
        bus.ld_data = 16'h00C3;
        tick();
        bus.ld_done = 1'b0;
        n_checks++;
        if (bus.status_register !== 16'h00C3) begin
            $display("FAIL load_sr_value: got %h expected 00c3", bus.status_register);
            n_fail++;
        end
    endtask

    task automatic test_overrun();
        bus.ld_issue = 1'b1;
        bus.ld_dest  = 4'd5;
        tick();
        bus.ld_dest = 4'd6;
        tick();
        bus.ld_issue = 1'b0;
        n_checks++;
        if ({bus.ld_overrun, bus.ld_busy} !== 2'b11) begin
            $display("FAIL overrun_set: got overrun/busy %b expected 11", {bus.ld_overrun, bus.ld_busy});
            n_fail++;
        end
        bus.ld_done = 1'b1;
        bus.ld_data = 16'h0077;
        tick();
        bus.ld_done  = 1'b0;
        bus.other_id = 4'd5;
        #1;
        n_checks++;
        if (bus.other_register !== 16'h0077) begin
            $display("FAIL overrun_r5: got %h expected 0077", bus.other_register);
            n_fail++;
        end
        bus.other_id = 4'd6;
        #1;
        n_checks++;
        if (bus.other_register !== 16'h0000) begin
            $display("FAIL overrun_r6: got %h expected 0000", bus.other_register);
            n_fail++;
        end
        n_checks++;
        if ({bus.ld_overrun, bus.ld_busy} !== 2'b10) begin
            $display("FAIL overrun_sticky: got overrun/busy %b expected 10", {bus.ld_overrun, bus.ld_busy});
            n_fail++;
        end
    endtask

    task automatic test_back_to_back();
        bus.ld_issue = 1'b1;
        bus.ld_dest  = 4'd4;
        tick();
        bus.ld_done  = 1'b1;
        bus.ld_data  = 16'h0044;
        bus.ld_dest  = 4'd10;
        tick();
        bus.ld_issue = 1'b0;
        bus.ld_data  = 16'h00AA;
        bus.other_id = 4'd4;
        #1;
        n_checks++;
        if ({bus.ld_busy, bus.other_register} !== {1'b1, 16'h0044}) begin
            $display("FAIL b2b_first: got busy %b r4 %h expected 1 0044", bus.ld_busy, bus.other_register);
            n_fail++;
        end
        tick();
        bus.ld_done  = 1'b0;
        bus.other_id = 4'd10;
        #1;
        n_checks++;
        if ({bus.ld_busy, bus.other_register} !== {1'b0, 16'h00AA}) begin
            $display("FAIL b2b_second: got busy %b r10 %h expected 0 00aa", bus.ld_busy, bus.other_register);
            n_fail++;
        end
    endtask

    task automatic test_reset_midload();
        bus.ld_issue = 1'b1;
        bus.ld_dest  = 4'd2;
        tick();
        bus.ld_issue = 1'b0;
        n_checks++;
        if (bus.ld_busy !== 1'b1) begin
            $display("FAIL midload_busy: got %b expected 1", bus.ld_busy);
            n_fail++;
        end
        #2;
        reset = 1'b1;
        #1;
        n_checks++;
        if ({bus.ld_busy, bus.ld_overrun} !== 2'b00) begin
            $display("FAIL async_reset_flags: got busy/overrun %b expected 00", {bus.ld_busy, bus.ld_overrun});
            n_fail++;
        end
        n_checks++;
        if (bus.program_counter !== 16'h0100) begin
            $display("FAIL async_reset_pc: got %h expected 0100", bus.program_counter);
            n_fail++;
        end
        tick();
        reset = 1'b0;
        bus.ld_done  = 1'b1;
        bus.ld_data  = 16'h2222;
        bus.other_id = 4'd2;
        tick();
        bus.ld_done = 1'b0;
        n_checks++;
        if ({bus.ld_busy, bus.other_register} !== {1'b0, 16'h0000}) begin
            $display("FAIL late_done_ignored: got busy %b r2 %h expected 0 0000", bus.ld_busy, bus.other_register);
            n_fail++;
        end
    endtask

    initial begin
        test_reset();
        test_writeback();
        test_pc();
        test_load();
        test_overrun();
        test_back_to_back();
        test_reset_midload();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
